dds_wave_gen: RTL and testbench

Parametrised direct-digital-synthesis waveform generator. It replaces the fixed 128-step sine sweep with a programmable phase accumulator, true quarter-wave symmetry (address mirroring plus amplitude sign flip), configurable table/output widths and selectable waveform modes. It feeds the parallel resistor-ladder DAC pins through the top-level pin assignment, and drives `sample` directly with no restore stage.

---
 rtl/dds_wave_gen.sv | 151 +++++++++++++++
 tb/tb_dds_wave_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dds_wave_gen.sv
`default_nettype none
// ============================================================================
// Module      : dds_wave_gen
// Description : DDS waveform generator with quarter-wave sine table and
//               4-stage pipeline. Define DDS_WAVE_MODES_EN to add the square,
//               triangle and sawtooth modes.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_wave_gen #(
  parameter int    OUT_WIDTH   = 10,
  parameter int    ADDR_WIDTH  = 7,
  parameter int    PHASE_WIDTH = 16,
  parameter string INIT_FILE   = "sine.txt"
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [PHASE_WIDTH-1:0] tune,
  input  logic                   phase_load,
  input  logic [PHASE_WIDTH-1:0] phase_in,
  input  logic [1:0]             mode,
  output logic [OUT_WIDTH-1:0]   sample,
  output logic                   sample_valid,
  output logic                   wrap
);

  localparam int                 c_depth = 2 ** ADDR_WIDTH;
  localparam int                 c_mag_w = OUT_WIDTH - 1;
  localparam longint             c_full  = (longint'(1) << (OUT_WIDTH - 1)) - 1;
  localparam logic [OUT_WIDTH-1:0] c_mid = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  // Bhaskara sine approximation, exact at 0 and 90 degrees (entries 0 and depth-1).
  function automatic logic [OUT_WIDTH-2:0] f_sine_mag(input int k);
    longint m, p, den;
    m   = longint'(c_depth - 1);
    p   = longint'(k) * (2 * m - longint'(k));
    den = 5 * m * m - p;
    return c_mag_w'((4 * p * c_full + den / 2) / den);
  endfunction

  function automatic logic [OUT_WIDTH-2:0] f_ramp_mag(input int k);
    return c_mag_w'((longint'(k) * c_full) / longint'(c_depth - 1));
  endfunction

  logic [OUT_WIDTH-2:0] w_rom [c_depth];

  for (genvar k = 0; k < c_depth; k++) begin : g_rom
    if (INIT_FILE == "") begin : g_ramp
      assign w_rom[k] = f_ramp_mag(k);
    end else begin : g_sine
      assign w_rom[k] = f_sine_mag(k);
    end
  end

  // E0: phase accumulator
  logic [PHASE_WIDTH-1:0] acc_q, acc_d;
  logic [PHASE_WIDTH:0]   w_sum;
  logic                   wrap_q, wrap_d;
  logic                   vld0_q, vld1_q, vld2_q;

  always_comb begin
    w_sum  = {1'b0, acc_q} + {1'b0, tune};
    acc_d  = acc_q;
    wrap_d = 1'b0;
    if (phase_load) begin
      acc_d = phase_in;
    end else if (enable) begin
      acc_d  = w_sum[PHASE_WIDTH-1:0];
      wrap_d = w_sum[PHASE_WIDTH];
    end
  end

  // E1: quadrant-mirrored table address
  logic [ADDR_WIDTH-1:0] w_idx, addr1_d, addr1_q;
  logic [1:0]            q1_q, q2_q;
  logic [OUT_WIDTH-2:0]  mag2_q;

  assign w_idx   = acc_q[PHASE_WIDTH-3 -: ADDR_WIDTH];
  assign addr1_d = acc_q[PHASE_WIDTH-2] ? ~w_idx : w_idx;

  always_ff @(posedge clk) begin
    addr1_q <= addr1_d;
    q1_q    <= acc_q[PHASE_WIDTH-1 -: 2];
    mag2_q  <= w_rom[addr1_q];
    q2_q    <= q1_q;
  end

  // E3 output selection
  logic [OUT_WIDTH-1:0] w_sine, sample_d, sample_q;
  logic                 sample_valid_q;

  assign w_sine = q2_q[1] ? {1'b0, ~mag2_q} : {1'b1, mag2_q};

`ifdef DDS_WAVE_MODES_EN
  logic [1:0]         mode1_q, mode2_q;
  logic [OUT_WIDTH:0] ph1_q, ph2_q;

  always_ff @(posedge clk) begin
    mode1_q <= mode;
    ph1_q   <= acc_q[PHASE_WIDTH-1 -: OUT_WIDTH+1];
    mode2_q <= mode1_q;
    ph2_q   <= ph1_q;
  end

  // ph2_q[OUT_WIDTH] is the phase MSB; the bits below it are the triangle ramp.
  always_comb begin
    sample_d = w_sine;
    case (mode2_q)
      2'd1:    sample_d = {OUT_WIDTH{~ph2_q[OUT_WIDTH]}};
      2'd2:    sample_d = ph2_q[OUT_WIDTH] ? ~ph2_q[OUT_WIDTH-1:0] : ph2_q[OUT_WIDTH-1:0];
      2'd3:    sample_d = ph2_q[OUT_WIDTH:1];
      default: sample_d = w_sine;
    endcase
  end
`else
  logic w_unused_mode;
  assign w_unused_mode = ^mode;

  always_comb begin
    sample_d = w_sine;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q          <= '0;
      wrap_q         <= 1'b0;
      vld0_q         <= 1'b0;
      vld1_q         <= 1'b0;
      vld2_q         <= 1'b0;
      sample_q       <= c_mid;
      sample_valid_q <= 1'b0;
    end else begin
      acc_q          <= acc_d;
      wrap_q         <= wrap_d;
      vld0_q         <= enable | phase_load;
      vld1_q         <= vld0_q;
      vld2_q         <= vld1_q;
      sample_valid_q <= vld2_q;
      if (vld2_q) begin
        sample_q <= sample_d;
      end
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign wrap         = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_wave_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_wave_gen
// Description : Scoreboard bench for dds_wave_gen at default parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_wave_gen;

  logic        clk = 1'b0;
  logic        reset, enable, phase_load;
  logic [15:0] tune, phase_in;
  logic [1:0]  mode;
  logic [9:0]  sample;
  logic        sample_valid, wrap;

  always #5 clk = ~clk;

  dds_wave_gen #(
    .OUT_WIDTH  (10),
    .ADDR_WIDTH (7),
    .PHASE_WIDTH(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .tune        (tune),
    .phase_load  (phase_load),
    .phase_in    (phase_in),
    .mode        (mode),
    .sample      (sample),
    .sample_valid(sample_valid),
    .wrap        (wrap)
  );

  typedef struct {
    logic       chk;
    logic [9:0] exp;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  logic [9:0] sweep_log[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [15:0] m_acc;
  logic [1:0]  cur_mode;

  // Expected outputs for acc = 0, 0x4000, 0x8000, 0xC000 (t[0]=0, t[127]=511)
  logic [9:0] pat_sine [4] = '{10'd512, 10'd1023, 10'd511, 10'd0};
  logic [9:0] pat_sq   [4] = '{10'd1023, 10'd1023, 10'd0, 10'd0};
  logic [9:0] pat_tri  [4] = '{10'd0, 10'd512, 10'd1023, 10'd511};
  logic [9:0] pat_saw  [4] = '{10'd0, 10'd256, 10'd512, 10'd768};

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sample_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL stale_sample: got %0d, expected no valid sample", sample);
      end else begin
        e = sb.pop_front();
        if (e.tag == "sweep") sweep_log.push_back(sample);
        if (e.chk) begin
          n_vec++;
          if (sample !== e.exp) begin
            n_err++;
            $display("FAIL %s: sample got %0d, expected %0d", e.tag, sample, e.exp);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic step(input logic en, input logic ld, input logic [15:0] pin,
                      input logic [15:0] tn, input logic chk, input logic [9:0] exp,
                      input string tag);
    logic [16:0] s;
    logic        exp_wrap;
    exp_t        e;
    enable     = en;
    phase_load = ld;
    phase_in   = pin;
    tune       = tn;
    mode       = cur_mode;
    exp_wrap   = 1'b0;
    s = {1'b0, m_acc} + {1'b0, tn};
    if (ld) begin
      m_acc = pin;
    end else if (en) begin
      m_acc    = s[15:0];
      exp_wrap = s[16];
    end
    if (en || ld) begin
      e.chk = chk;
      e.exp = exp;
      e.tag = tag;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    check({"wrap_", tag}, {15'b0, wrap}, {15'b0, exp_wrap});
    @(negedge clk);
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 10'd0, "idle");
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int viol;
    reset      = 1'b1;
    enable     = 1'b1;
    phase_load = 1'b0;
    phase_in   = 16'h0;
    tune       = 16'h4000;
    mode       = 2'd0;
    cur_mode   = 2'd0;
    m_acc      = 16'h0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_sample", {6'b0, sample}, 16'd512);
    check("reset_valid", {15'b0, sample_valid}, 16'd0);
    check("reset_wrap", {15'b0, wrap}, 16'd0);

    // Release with enable held; tune=0x4000 gives the four-point sine cycle.
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step(1'b1, 1'b0, 16'h0, 16'h4000, 1'b1, pat_sine[e % 4], "tune4000");
      if (e <= 4) check("valid_after_release", {15'b0, sample_valid}, (e == 4) ? 16'd1 : 16'd0);
    end
    flush();

    // Load priority over enable, no wrap on load, 3-edge latency
    step(1'b0, 1'b1, 16'hC000, 16'h0, 1'b1, 10'd0, "load_c000");
    step(1'b1, 1'b1, 16'h8000, 16'h4000, 1'b1, 10'd511, "load_en_8000");
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 10'd0, "idle");
    check("load_latency_early", {15'b0, sample_valid}, 16'd0);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 10'd0, "idle");
    check("load_latency_on_time", {15'b0, sample_valid}, 16'd1);
    flush();

    // tune = 0 holds the phase
    step(1'b0, 1'b1, 16'h4000, 16'h0, 1'b1, 10'd1023, "tune0_load");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 10'd1023, "tune0");
    flush();

    // Waveform modes (sine pattern when the mode feature is compiled out)
    for (int m = 1; m <= 3; m++) begin
      cur_mode = 2'(m);
      for (int k = 0; k < 4; k++) begin
        logic [9:0] ev;
        ev = pat_sine[k];
`ifdef DDS_WAVE_MODES_EN
        if (m == 1) ev = pat_sq[k];
        else if (m == 2) ev = pat_tri[k];
        else ev = pat_saw[k];
`endif
        step(1'b1, k == 0, 16'h0, 16'h4000, 1'b1, ev, "mode");
      end
      flush();
    end

    // Sine sweep, tune = 128: one table step per clock, wrap every 512 clocks
    cur_mode = 2'd0;
    step(1'b0, 1'b1, 16'h0, 16'd128, 1'b1, 10'd512, "sweep");
    for (int j = 1; j <= 1024; j++)
      step(1'b1, 1'b0, 16'h0, 16'd128, (j % 128) == 0, pat_sine[(j / 128) % 4], "sweep");
    flush();
    check("sweep_len", 16'(sweep_log.size()), 16'd1025);
    if (sweep_log.size() == 1025) begin
      for (int k = 0; k < 768; k++)
        check("sweep_half_sum", 16'(int'(sweep_log[k]) + int'(sweep_log[k + 256])), 16'd1023);
      viol = 0;
      for (int k = 0; k < 511; k++) begin
        if ((k < 128 || k >= 384) ? (sweep_log[k] > sweep_log[k + 1])
                                  : (sweep_log[k] < sweep_log[k + 1])) viol++;
      end
      check("sweep_monotonic", 16'(viol), 16'd0);
    end

    // Reset pulse during a running sweep
    for (int j = 0; j < 5; j++) step(1'b1, 1'b0, 16'h0, 16'd128, 1'b0, 10'd0, "pre_reset");
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_sample", {6'b0, sample}, 16'd512);
    check("midreset_valid", {15'b0, sample_valid}, 16'd0);
    check("midreset_wrap", {15'b0, wrap}, 16'd0);
    sb.delete();
    m_acc = 16'h0;
    @(negedge clk);
    reset = 1'b0;
    flush();
    step(1'b0, 1'b1, 16'h0, 16'd128, 1'b1, 10'd512, "post_reset");
    step(1'b1, 1'b0, 16'h0, 16'h4000, 1'b1, 10'd1023, "post_reset");
    flush();

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 16'(sb.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
